// File: rtl/fetch_decode.sv
// Instruction fetch/decode controller between the PC and execute.
// Fetches over req/ack, decodes control ops, hands the rest to execute.
module fetch_decode #(
    parameter int AW  = 4,
    parameter int OPW = 4,
    localparam int IW = OPW + AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    input  logic          z_flag,
    output logic          op_valid,
    output logic [OPW-1:0] op_code,
    output logic [AW-1:0] op_arg,
    input  logic          exec_done,
    output logic          pc_step,
    output logic          jmp,
    output logic [AW-1:0] offset,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_STEP,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP = '0;
    localparam logic [OPW-1:0] OP_JMP = OPW'(1);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(2);
    localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

    state_t state;
    state_t nxt;

    logic [IW-1:0]  ir;
    logic [AW-1:0]  addr_q;
    logic [OPW-1:0] opc;
    logic [AW-1:0]  opr;
    logic           is_nop;
    logic           is_jmp;
    logic           is_jz;
    logic           is_hlt;
    logic           is_exec;

    assign opc = ir[IW-1:AW];
    assign opr = ir[AW-1:0];

    // Classify the opcode held in the IR.
    always_comb begin
        is_nop  = (opc == OP_NOP);
        is_jmp  = (opc == OP_JMP);
        is_jz   = (opc == OP_JZ);
        is_hlt  = (opc == OP_HLT);
        is_exec = !(is_nop || is_jmp || is_jz || is_hlt);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic; acks and dones only count in their own state.
    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH:  nxt = S_WAIT;
            S_WAIT:   if (imem_ack) nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_hlt:  nxt = S_HALT;
                    is_exec: nxt = S_EXEC;
                    default: nxt = S_STEP;
                endcase
            end
            S_EXEC:   if (exec_done) nxt = S_STEP;
            S_STEP:   nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // Fetch address, IR and jump outputs; jmp/offset hold until next DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ir     <= '0;
            jmp    <= 1'b0;
            offset <= '0;
        end else begin
            if (state == S_FETCH) begin
                addr_q <= pc;
            end
            if (state == S_WAIT && imem_ack) begin
                ir <= imem_data;
            end
            if (state == S_DECODE) begin
                jmp    <= is_jmp || (is_jz && z_flag);
                offset <= (is_jmp || is_jz) ? opr : '0;
            end
        end
    end

    // Request is forced low while reset is held, even though state is FETCH.
    assign imem_req  = rst_n && (state == S_FETCH || state == S_WAIT);
    assign imem_addr = !rst_n ? '0 :
                       (state == S_FETCH) ? pc : addr_q;

    assign op_valid = (state == S_DECODE) && is_exec;
    assign op_code  = opc;
    assign op_arg   = opr;
    assign pc_step  = (state == S_STEP);
    assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode.
// Drives a downstream PC model and a simple instruction memory.
module tb_fetch_decode;

    localparam int AW  = 4;
    localparam int OPW = 4;
    localparam int IW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  pc;
    logic           imem_req;
    logic [AW-1:0]  imem_addr;
    logic           imem_ack;
    logic [IW-1:0]  imem_data;
    logic           z_flag = 1'b0;
    logic           op_valid;
    logic [OPW-1:0] op_code;
    logic [AW-1:0]  op_arg;
    logic           exec_done = 1'b0;
    logic           pc_step;
    logic           jmp;
    logic [AW-1:0]  offset;
    logic           halted;

    logic [AW-1:0]  pc_init = '0;
    logic [IW-1:0]  mem_word = '0;
    logic           ack_en = 1'b0;

    int checks = 0;
    int errors = 0;

    fetch_decode #(.AW(AW), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .z_flag    (z_flag),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .op_arg    (op_arg),
        .exec_done (exec_done),
        .pc_step   (pc_step),
        .jmp       (jmp),
        .offset    (offset),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign imem_ack  = ack_en;
    assign imem_data = mem_word;

    // Downstream program counter: advances only on pc_step, wraps mod 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= pc_init;
        end else if (pc_step) begin
            pc <= jmp ? pc + offset : pc + AW'(1);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic [AW-1:0] p,
                              input logic [IW-1:0] w,
                              input logic a);
        @(negedge clk);
        rst_n    = 1'b1;
        pc_init  = p;
        mem_word = w;
        ack_en   = a;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset values, with a non-zero pc visible during reset
        hold_reset(4'd9, 8'h00, 1'b1);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_step", pc_step, 0);
        chk("rst_opv", op_valid, 0);
        chk("rst_jmp", jmp, 0);
        chk("rst_off", offset, 0);
        chk("rst_halt", halted, 0);
        chk("rst_ir", op_code, 0);

        // NOP loop: 4-cycle cadence
        release_rst();
        chk("nop_c1_req", imem_req, 1);
        chk("nop_c1_addr", imem_addr, 9);
        chk("nop_c1_step", pc_step, 0);
        next();
        chk("nop_c2_req", imem_req, 1);
        chk("nop_c2_addr", imem_addr, 9);
        next();
        chk("nop_c3_req", imem_req, 0);
        chk("nop_c3_step", pc_step, 0);
        chk("nop_c3_opv", op_valid, 0);
        next();
        chk("nop_c4_step", pc_step, 1);
        chk("nop_c4_jmp", jmp, 0);
        next();
        chk("nop_c5_req", imem_req, 1);
        chk("nop_c5_addr", imem_addr, 10);
        next();
        next();
        next();
        chk("nop_c8_step", pc_step, 1);
        next();
        chk("nop_c9_addr", imem_addr, 11);

        // JMP +5 from 3
        hold_reset(4'd3, 8'h15, 1'b1);
        release_rst();
        next();
        next();
        next();
        chk("jmp_step", pc_step, 1);
        chk("jmp_jmp", jmp, 1);
        chk("jmp_off", offset, 5);
        next();
        chk("jmp_addr", imem_addr, 8);

        // JMP +3 from 14 wraps to 1
        hold_reset(4'd14, 8'h13, 1'b1);
        release_rst();
        next();
        next();
        next();
        chk("wrap_jmp", jmp, 1);
        chk("wrap_off", offset, 3);
        next();
        chk("wrap_addr", imem_addr, 1);

        // JZ taken
        z_flag = 1'b1;
        hold_reset(4'd2, 8'h24, 1'b1);
        release_rst();
        next();
        next();
        next();
        chk("jz1_step", pc_step, 1);
        chk("jz1_jmp", jmp, 1);
        chk("jz1_off", offset, 4);
        next();
        chk("jz1_addr", imem_addr, 6);

        // JZ not taken
        z_flag = 1'b0;
        hold_reset(4'd2, 8'h24, 1'b1);
        release_rst();
        next();
        next();
        next();
        chk("jz0_step", pc_step, 1);
        chk("jz0_jmp", jmp, 0);
        chk("jz0_off", offset, 4);
        next();
        chk("jz0_addr", imem_addr, 3);

        // Exec op with early exec_done during op_valid
        exec_done = 1'b1;
        hold_reset(4'd0, 8'h5A, 1'b1);
        release_rst();
        next();
        next();
        chk("ex_c3_opv", op_valid, 1);
        chk("ex_c3_code", op_code, 5);
        chk("ex_c3_arg", op_arg, 4'hA);
        chk("ex_c3_step", pc_step, 0);
        next();
        exec_done = 1'b0;
        chk("ex_c4_opv", op_valid, 0);
        chk("ex_c4_step", pc_step, 0);
        chk("ex_c4_code", op_code, 5);
        next();
        chk("ex_c5_step", pc_step, 0);
        next();
        exec_done = 1'b1;
        chk("ex_c6_step", pc_step, 0);
        chk("ex_c6_arg", op_arg, 4'hA);
        next();
        exec_done = 1'b0;
        chk("ex_c7_step", pc_step, 1);
        chk("ex_c7_jmp", jmp, 0);
        chk("ex_c7_opv", op_valid, 0);
        next();
        chk("ex_c8_addr", imem_addr, 1);

        // Ack delayed: request and address stay put
        hold_reset(4'd6, 8'h00, 1'b0);
        release_rst();
        chk("dly_c1_addr", imem_addr, 6);
        for (int i = 0; i < 5; i++) begin
            next();
            chk("dly_wait_req", imem_req, 1);
            chk("dly_wait_addr", imem_addr, 6);
        end
        next();
        chk("dly_c7_req", imem_req, 1);
        ack_en = 1'b1;
        next();
        chk("dly_c8_req", imem_req, 0);
        next();
        chk("dly_c9_step", pc_step, 1);

        // Reset in the third wait cycle; late ack ignored
        hold_reset(4'd6, 8'h00, 1'b0);
        release_rst();
        next();
        next();
        next();
        chk("mid_w3_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_addr", imem_addr, 0);
        mem_word = 8'h5A;
        ack_en   = 1'b1;
        next();
        chk("mid_late_ir", op_code, 0);
        chk("mid_late_req", imem_req, 0);
        release_rst();
        chk("mid_c1_req", imem_req, 1);
        next();
        chk("mid_c2_req", imem_req, 1);
        chk("mid_c2_opv", op_valid, 0);
        next();
        chk("mid_c3_opv", op_valid, 1);

        // HLT: idle until reset
        hold_reset(4'd4, 8'hF0, 1'b1);
        release_rst();
        next();
        next();
        chk("hlt_c3_halt", halted, 0);
        next();
        chk("hlt_c4_halt", halted, 1);
        for (int i = 0; i < 20; i++) begin
            next();
            chk("hlt_req", imem_req, 0);
            chk("hlt_step", pc_step, 0);
            chk("hlt_opv", op_valid, 0);
            chk("hlt_halt", halted, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("hlt_rst_halt", halted, 0);
        mem_word = 8'h00;
        next();
        release_rst();
        chk("hlt_re_req", imem_req, 1);
        chk("hlt_re_addr", imem_addr, 4);
        next();
        chk("hlt_re_c2_req", imem_req, 1);
        chk("hlt_re_c2_halt", halted, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
